// File: rtl/arbitro_salida_rr_if.sv
// Handshake bundle between the output round-robin arbiter, the four class FIFOs
// and the four destination FIFOs.
interface arbitro_salida_rr_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 5
);
    logic [3:0]          fifo_empty;
    logic [4*DATA_W-1:0] fifo_data;
    logic [3:0]          out_almost_full;
    logic [1:0]          cnt_sel;
    logic [3:0]          pop;
    logic [3:0]          push;
    logic [DATA_W-1:0]   data_out;
    logic [CNT_W-1:0]    cnt_out;
    logic                idle;

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        input  out_almost_full,
        input  cnt_sel,
        output pop,
        output push,
        output data_out,
        output cnt_out,
        output idle
    );

    modport master (
        output fifo_empty,
        output fifo_data,
        output out_almost_full,
        output cnt_sel,
        input  pop,
        input  push,
        input  data_out,
        input  cnt_out,
        input  idle
    );
endinterface

// File: rtl/arbitro_salida_rr.sv
// Output-side arbiter: round-robin pops of four class FIFOs, steering by the word's
// destination field into four destination FIFOs, with per-destination word counters.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RESET  | reset_L asserted, everything held at reset values
// ST_INIT   | one settling cycle after reset release, no traffic
// ST_IDLE   | no class FIFO has data and nothing is in flight
// ST_ACTIVE | granting pops round-robin and draining the pipeline
module arbitro_salida_rr #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 5
) (
    input logic               clk,
    input logic               reset_L,
    arbitro_salida_rr_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_rr_ptr;
    logic               r_s1_valid;
    logic [1:0]         r_s1_idx;
    logic               r_out_valid;
    logic [3:0]         r_push;
    logic [DATA_W-1:0]  r_data_out;
    logic [CNT_W-1:0]   r_count [4];

    logic               w_grant;
    logic [1:0]         w_grant_idx;
    logic [3:0]         w_pop;
    logic               w_stall;
    logic               w_all_empty;
    logic               w_pipe_empty;
    logic [DATA_W-1:0]  w_cap_word;
    logic [1:0]         w_cap_dest;
    logic [1:0]         w_out_dest;

    assign w_stall      = |bus.out_almost_full;
    assign w_all_empty  = &bus.fifo_empty;
    assign w_pipe_empty = !r_s1_valid && !r_out_valid;

    // Scan offsets from high to low so the nearest non-empty channel after rr_ptr wins.
    always_comb begin
        logic [1:0] idx;
        w_grant     = 1'b0;
        w_grant_idx = r_rr_ptr;
        idx         = r_rr_ptr;
        for (int j = 3; j >= 0; j--) begin
            idx = r_rr_ptr + 2'(j);
            if (!bus.fifo_empty[idx]) begin
                w_grant     = 1'b1;
                w_grant_idx = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT:   w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (!w_all_empty) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_all_empty && w_pipe_empty) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:   w_state_nxt = ST_RESET;
        endcase
    end

    // Any almost_full stalls every channel; words already popped still drain.
    always_comb begin
        w_pop = 4'b0000;
        if (r_state == ST_ACTIVE && !w_stall && w_grant) begin
            w_pop[w_grant_idx] = 1'b1;
        end
    end

    assign w_cap_word = bus.fifo_data[int'(r_s1_idx)*DATA_W +: DATA_W];
    assign w_cap_dest = w_cap_word[DATA_W-1:DATA_W-2];
    assign w_out_dest = r_data_out[DATA_W-1:DATA_W-2];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_rr_ptr    <= 2'd0;
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= 2'd0;
            r_out_valid <= 1'b0;
            r_push      <= 4'b0000;
            r_data_out  <= '0;
        end else begin
            r_s1_valid <= |w_pop;
            if (|w_pop) begin
                r_s1_idx <= w_grant_idx;
                r_rr_ptr <= w_grant_idx + 2'd1;
            end
            // The class FIFO presents the popped word one cycle after the pop.
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_push     <= 4'b0001 << w_cap_dest;
                r_data_out <= w_cap_word;
            end else begin
                r_push <= 4'b0000;
            end
        end
    end

    // Counters advance on the cycle after push, so a same-cycle read sees the old value.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                r_count[i] <= '0;
            end
        end else if (r_out_valid) begin
            r_count[w_out_dest] <= r_count[w_out_dest] + CNT_W'(1);
        end
    end

    assign bus.pop      = w_pop;
    assign bus.push     = r_push;
    assign bus.data_out = r_data_out;
    assign bus.cnt_out  = r_count[bus.cnt_sel];
    assign bus.idle     = (r_state == ST_IDLE);

endmodule

// File: tb/tb_arbitro_salida_rr.sv
// Bench for arbitro_salida_rr: directed vector table, corner sequences and a random
// run against a cycle-indexed reference model with queue-based class FIFOs.
module tb_arbitro_salida_rr;
    localparam int DATA_W = 6;
    localparam int CNT_W  = 5;
    localparam int M_RST  = 0;
    localparam int M_INIT = 1;
    localparam int M_IDLE = 2;
    localparam int M_ACT  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    arbitro_salida_rr_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    arbitro_salida_rr #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_L (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit          load;
        logic [3:0]  af;
        logic [3:0]  e_pop;
        logic [3:0]  e_push;
        logic [5:0]  e_data;
        logic [4:0]  e_cnt;
        bit          e_idle;
    } vec_t;

    vec_t tbl [15];

    logic [DATA_W-1:0] q [4][$];
    logic [DATA_W-1:0] m_sched [int];
    logic [3:0]        obs_push [$];
    logic [3:0]        steer_exp [5];
    int                m_mode;
    int                m_ptr;
    int                m_cnt [4];
    int                n_vec = 0;
    int                n_bad = 0;
    int                cyc   = 0;

    logic [3:0]        s_pop;
    logic [3:0]        s_push;
    logic [DATA_W-1:0] s_data;
    logic [CNT_W-1:0]  s_cnt;
    logic              s_idle;

    function automatic void chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
        end
    endfunction

    function automatic bit all_q_empty();
        return q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0;
    endfunction

    task automatic assert_reset();
        rst_n  = 1'b0;
        m_mode = M_RST;
        m_ptr  = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_sched.delete();
    endtask

    // One clock cycle: drive flags, sample mid-cycle, compare, advance the model, move the FIFOs.
    task automatic tick();
        logic [3:0]        e_pop;
        logic [3:0]        e_push;
        logic [DATA_W-1:0] w;
        logic [1:0]        d;
        int                k;
        bit                pend_now;
        bit                pend_next;
        for (int i = 0; i < 4; i++) bus.fifo_empty[i] = (q[i].size() == 0);
        @(negedge clk);
        s_pop  = bus.pop;
        s_push = bus.push;
        s_data = bus.data_out;
        s_cnt  = bus.cnt_out;
        s_idle = bus.idle;
        if (s_push != 4'b0000) obs_push.push_back(s_push);

        e_pop = 4'b0000;
        if (m_mode == M_ACT && bus.out_almost_full == 4'b0000) begin
            for (int j = 0; j < 4; j++) begin
                k = (m_ptr + j) % 4;
                if (e_pop == 4'b0000 && !bus.fifo_empty[k]) e_pop[k] = 1'b1;
            end
        end
        e_push = 4'b0000;
        w      = '0;
        if (m_sched.exists(cyc)) begin
            w      = m_sched[cyc];
            d      = w[DATA_W-1:DATA_W-2];
            e_push = 4'b0001 << d;
        end
        chk("pop", int'(s_pop), int'(e_pop));
        chk("push", int'(s_push), int'(e_push));
        if (e_push != 4'b0000) chk("data_out", int'(s_data), int'(w));
        chk("cnt_out", int'(s_cnt), m_cnt[bus.cnt_sel]);
        chk("idle", int'(s_idle), (m_mode == M_IDLE) ? 1 : 0);

        if (rst_n) begin
            pend_now  = m_sched.exists(cyc);
            pend_next = m_sched.exists(cyc + 1);
            for (int j = 0; j < 4; j++) begin
                if (e_pop[j] && q[j].size() > 0) begin
                    m_sched[cyc + 2] = q[j][0];
                    m_ptr = (j + 1) % 4;
                end
            end
            if (pend_now) begin
                d = w[DATA_W-1:DATA_W-2];
                m_cnt[d] = (m_cnt[d] + 1) % (1 << CNT_W);
                m_sched.delete(cyc);
            end
            case (m_mode)
                M_RST:  m_mode = M_INIT;
                M_INIT: m_mode = M_IDLE;
                M_IDLE: if (bus.fifo_empty != 4'hF) m_mode = M_ACT;
                default: if (bus.fifo_empty == 4'hF && !pend_now && !pend_next) m_mode = M_IDLE;
            endcase
        end

        @(posedge clk);
        #1;
        cyc++;
        for (int j = 0; j < 4; j++) begin
            if (s_pop[j] && q[j].size() > 0) bus.fifo_data[j*DATA_W +: DATA_W] = q[j].pop_front();
        end
    endtask

    task automatic do_reset();
        assert_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(m_mode == M_IDLE && all_q_empty()) && n < max_cyc);
        if (!(m_mode == M_IDLE && all_q_empty())) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout at cycle %0d: got busy after %0d cycles, expected idle", cyc, n);
        end
    endtask

    initial begin
        int n0;
        int np;
        logic [DATA_W-1:0] rw;

        bus.fifo_empty      = 4'hF;
        bus.fifo_data       = '0;
        bus.out_almost_full = 4'h0;
        bus.cnt_sel         = 2'd0;
        m_mode = M_RST;
        m_ptr  = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;

        //        rst  load af    pop   push  data   cnt  idle
        tbl[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 6'h00, 5'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 6'h00, 5'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 6'h00, 5'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 6'h00, 5'd0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 6'h00, 5'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 6'h00, 5'd0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 4'h0, 4'h1, 4'h0, 6'h00, 5'd0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 4'h0, 4'h2, 4'h0, 6'h00, 5'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 4'h0, 4'h4, 4'h8, 6'h31, 5'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 4'h0, 4'h8, 4'h2, 6'h12, 5'd0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 4'h0, 4'h1, 4'h4, 6'h23, 5'd0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 6'h04, 5'd0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 6'h05, 5'd1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 6'h00, 5'd2, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 6'h00, 5'd2, 1'b1};

        for (int i = 0; i < 15; i++) begin
            rst_n = tbl[i].rst_n;
            if (tbl[i].load) begin
                q[0].push_back(6'h31);
                q[0].push_back(6'h05);
                q[1].push_back(6'h12);
                q[2].push_back(6'h23);
                q[3].push_back(6'h04);
            end
            bus.out_almost_full = tbl[i].af;
            tick();
            chk("tbl_pop", int'(s_pop), int'(tbl[i].e_pop));
            chk("tbl_push", int'(s_push), int'(tbl[i].e_push));
            if (tbl[i].e_push != 4'h0) chk("tbl_data", int'(s_data), int'(tbl[i].e_data));
            chk("tbl_cnt", int'(s_cnt), int'(tbl[i].e_cnt));
            chk("tbl_idle", int'(s_idle), int'(tbl[i].e_idle));
        end

        // Steering: five words through channel 2 only.
        do_reset();
        steer_exp[0] = 4'h1; steer_exp[1] = 4'h2; steer_exp[2] = 4'h4;
        steer_exp[3] = 4'h8; steer_exp[4] = 4'h8;
        q[2].push_back(6'b00_0111);
        q[2].push_back(6'b01_0110);
        q[2].push_back(6'b10_0101);
        q[2].push_back(6'b11_0100);
        q[2].push_back(6'b11_0011);
        bus.cnt_sel = 2'd3;
        obs_push.delete();
        run_until_idle(40);
        tick();
        chk("steer_count", obs_push.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("steer_push", (i < obs_push.size()) ? int'(obs_push[i]) : 0, int'(steer_exp[i]));
        chk("steer_cnt3", int'(s_cnt), 2);

        // Backpressure: stall four cycles after three grants.
        do_reset();
        bus.cnt_sel = 2'd0;
        for (int c = 0; c < 4; c++)
            for (int n = 0; n < 3; n++) q[c].push_back(DATA_W'($urandom_range(0, 63)));
        tick();
        repeat (3) tick();
        bus.out_almost_full = 4'b0010;
        n0 = obs_push.size();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_pop", int'(s_pop), 0);
        end
        chk("bp_inflight", obs_push.size() - n0, 2);
        bus.out_almost_full = 4'b0000;
        tick();
        chk("bp_resume", int'(s_pop), 4'b1000);
        run_until_idle(40);

        // Counter wrap: 33 words to destination 0.
        do_reset();
        bus.cnt_sel = 2'd0;
        for (int i = 0; i < 33; i++) q[0].push_back({2'b00, 4'($urandom_range(0, 15))});
        run_until_idle(60);
        tick();
        chk("wrap_cnt0", int'(s_cnt), 1);

        // Asynchronous reset between pops and their pushes.
        do_reset();
        bus.cnt_sel = 2'd0;
        q[0].push_back(6'h05);
        q[1].push_back(6'h2A);
        q[2].push_back(6'h1B);
        tick();
        tick();
        tick();
        chk("mid_pop", int'(s_pop), 4'b0010);
        tick();
        assert_reset();
        for (int i = 0; i < 4; i++) begin
            bus.cnt_sel = 2'(i);
            tick();
            chk("mid_push", int'(s_push), 0);
            chk("mid_cnt", int'(s_cnt), 0);
        end
        rst_n = 1'b1;
        bus.cnt_sel = 2'd0;
        tick();
        tick();
        for (int c = 0; c < 4; c++) q[c].push_back(6'(8 + c));
        tick();
        tick();
        chk("restart_pop", int'(s_pop), 4'b0001);
        run_until_idle(40);

        // Random traffic, backpressure, counter reads and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                np = $urandom_range(0, 3);
                rw = DATA_W'($urandom_range(0, 63));
                if (q[np].size() < 6) q[np].push_back(rw);
            end
            if ($urandom_range(0, 15) == 0) bus.out_almost_full = 4'($urandom_range(0, 15));
            else if (bus.out_almost_full != 4'h0 && $urandom_range(0, 2) == 0) bus.out_almost_full = 4'h0;
            bus.cnt_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                assert_reset();
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        bus.out_almost_full = 4'h0;
        run_until_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/arbitro_salida_rr.md
# arbitro_salida_rr

Output-side arbiter between the four per-class FIFOs and the four destination FIFOs. Pops the class FIFOs in round-robin order, steers each word by its 2-bit destination field into one of four output FIFOs, and counts words delivered per destination. Consumes what the upstream class-steering arbiter wrote into the class FIFOs.

## Interface
Parameters:
- DATA_W, 6, word width; bits [DATA_W-1:DATA_W-2] are the destination field.
- CNT_W, 5, width of each per-destination word counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- fifo_empty  in  4  empty flags of class FIFOs 0..3.
- fifo_data  in  4*DATA_W  read data of class FIFOs; channel k occupies bits [k*DATA_W +: DATA_W].
- out_almost_full  in  4  almost-full flags of destination FIFOs 0..3.
- cnt_sel  in  2  selects which destination counter drives cnt_out.
- pop  out  4  one-hot (or zero) pop strobe to class FIFOs.
- push  out  4  one-hot (or zero) push strobe to destination FIFOs.
- data_out  out  DATA_W  word presented with push.
- cnt_out  out  CNT_W  value of counter cnt_sel.
- idle  out  1  high when in IDLE with no words in flight.

## Operation
- States: RESET (reset_L low), INIT, IDLE, ACTIVE.
- RESET → INIT on the first clock edge after reset_L rises; INIT → IDLE unconditionally after one cycle.
- IDLE → ACTIVE when any fifo_empty bit is 0. Pop is never asserted in IDLE.
- ACTIVE → IDLE when all fifo_empty bits are 1 and both pipeline stages are empty.
- Grant, in ACTIVE only: pick the first non-empty channel starting at rr_ptr, wrapping 3→0. Pop is combinational from registered state and inputs.
- If any out_almost_full bit is 1, pop = 0. This stall is conservative and global.
- After a grant on channel k, rr_ptr <= (k+1) mod 4. With no grant, rr_ptr holds.
- Empty channels are never popped. A single non-empty channel is popped every cycle.
- Stage 1 registers the pop valid bit and the channel index. In the following cycle, fifo_data of that channel is captured.
- Output stage: data_out <= captured word; push <= one-hot of dest = word[DATA_W-1:DATA_W-2]; push is 0 when no word was captured.
- Counters: count[dest] increments on every push. Each counter wraps at 2^CNT_W−1 → 0.
- cnt_out = count[cnt_sel], combinational read.
- idle = (state == IDLE).

## Timing
- Reset values: pop 0, push 0, data_out 0, all counters 0, rr_ptr 0, pipeline valid bits 0, idle 0 (state RESET). The same values apply while in INIT.
- FIFO read model: pop in cycle N gives data valid on fifo_data in cycle N+1.
- Latency: pop in cycle N → push and data_out in cycle N+2. One word per cycle maximum throughput.
- Words in flight are not cancelled by almost_full. Destination FIFOs therefore set their almost_full threshold at least 2 words below full.
- almost_full falling in cycle N allows a pop in cycle N.
- Reset asserted mid-operation clears the state immediately and asynchronously. Words in flight are dropped; counters are cleared.
- Simultaneous cases:
  - A grant and an almost_full rise in the same cycle: pop is suppressed.
  - A push and a counter read of the same destination in the same cycle: cnt_out shows the pre-increment value.

## Test plan
- Reset/INIT: hold reset_L low for 3 cycles, then release → all outputs 0 for the INIT cycle; idle = 1 from the next cycle.
- Round-robin: all four FIFOs non-empty, no almost_full → pop sequence 0001, 0010, 0100, 1000, 0001. The first push appears 2 cycles after the first pop.
- Steering and counters: words 6'b00_xxxx, 01, 10, 11, 11 popped from channel 2 only → push 0001, 0010, 0100, 1000, 1000. With cnt_sel = 3, cnt_out ends at 2.
- Backpressure: out_almost_full[1] = 1 for 4 cycles while traffic is pending → pop = 0 for those 4 cycles. The 2 in-flight words are still pushed, then pops resume at the rr_ptr position.
- Wrap: push 33 words to destination 0 with CNT_W = 5 → cnt_out = 1.
- Async reset mid-stream: drop reset_L between a pop and its push → push stays 0, counters read 0, rr_ptr restarts at channel 0.
